// File: rtl/simon_event_framer.sv
// Bins a DVS event stream into a two-plane binary occupancy frame and emits the
// frame whenever an event lands at or past the end of the current time window.
module simon_event_framer #(
  parameter int SENSOR_W    = 240,
  parameter int SENSOR_H    = 180,
  parameter int FRAME_W     = 34,
  parameter int FRAME_H     = 34,
  parameter int TIME_WINDOW = 100000,
  parameter int ADDR_OUT    = 6
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [33:0]                    timestamp_i,
  input  logic [13:0]                    x_coord_i,
  input  logic [13:0]                    y_coord_i,
  input  logic                           polarity_i,
  input  logic                           is_valid_i,
  output logic [FRAME_W*FRAME_H*2-1:0]   out_data_o,
  output logic [ADDR_OUT-1:0]            out_addr_o,
  output logic                           out_valid_o
);

  localparam int PLANE = FRAME_W * FRAME_H;
  localparam int NB    = PLANE * 2;
  localparam int IW    = $clog2(NB);

  typedef enum logic {UNARMED, ARMED} state_t;

  state_t              state_q, state_d;
  logic [33:0]         window_end;
  logic [NB-1:0]       frame;
  logic [ADDR_OUT-1:0] seq;

  logic                in_range;
  int                  xb, yb;
  logic [IW-1:0]       idx;
  logic [NB-1:0]       hit;
  logic                open_win, close_win;

  // Constant division keeps the binning exact for every in-range pixel.
  always_comb begin
    in_range = (x_coord_i < 14'(SENSOR_W)) && (y_coord_i < 14'(SENSOR_H));
    xb       = int'(x_coord_i) * FRAME_W / SENSOR_W;
    yb       = int'(y_coord_i) * FRAME_H / SENSOR_H;
    idx      = IW'(int'(polarity_i) * PLANE + yb * FRAME_W + xb);
    hit      = '0;
    if (in_range) hit[idx] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) state_q <= UNARMED;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (is_valid_i) state_d = ARMED;
  end

  always_comb begin
    open_win  = is_valid_i && (state_q == UNARMED);
    close_win = is_valid_i && (state_q == ARMED) && (timestamp_i >= window_end);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      window_end  <= '0;
      frame       <= '0;
      seq         <= '0;
      out_data_o  <= '0;
      out_addr_o  <= '0;
      out_valid_o <= 1'b0;
    end else begin
      out_valid_o <= close_win;
      if (close_win) begin
        // The closing event opens the next frame rather than joining the old one.
        out_data_o <= frame;
        out_addr_o <= seq;
        seq        <= seq + 1'b1;
        frame      <= hit;
      end else if (is_valid_i) begin
        frame <= frame | hit;
      end
      if (open_win || close_win) window_end <= timestamp_i + 34'(TIME_WINDOW);
    end
  end

endmodule

// File: tb/tb_simon_event_framer.sv
// Directed stimulus for simon_event_framer; expected frames are queued at issue
// time and a negedge monitor checks each emitted frame, address and timing.
module tb_simon_event_framer;

  localparam int NB = 2312;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [33:0]     ts  = '0;
  logic [13:0]     xc  = '0;
  logic [13:0]     yc  = '0;
  logic            pol = 1'b0;
  logic            vld = 1'b0;
  logic [NB-1:0]   out_data;
  logic [5:0]      out_addr;
  logic            out_valid;

  simon_event_framer dut (
    .clk_i(clk), .rst_i(rst), .timestamp_i(ts), .x_coord_i(xc), .y_coord_i(yc),
    .polarity_i(pol), .is_valid_i(vld), .out_data_o(out_data),
    .out_addr_o(out_addr), .out_valid_o(out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NB-1:0] data;
    logic [5:0]    addr;
    int            cyc;
  } exp_t;

  exp_t          q[$];
  int            checks = 0;
  int            errors = 0;
  int            pcyc   = 0;
  logic [NB-1:0] expf;

  always @(posedge clk) pcyc <= pcyc + 1;

  // Monitor: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (out_valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cyc=%0d addr=%0d", pcyc, out_addr);
      end else begin
        exp_t e;
        int fd;
        e = q.pop_front();
        if (e.cyc != pcyc) begin
          errors++;
          $display("FAIL pulse_cycle got=%0d exp=%0d", pcyc, e.cyc);
        end
        checks++;
        if (out_addr != e.addr) begin
          errors++;
          $display("FAIL frame_addr got=%0d exp=%0d", out_addr, e.addr);
        end
        checks++;
        if (out_data != e.data) begin
          fd = -1;
          for (int i = NB - 1; i >= 0; i--) if (out_data[i] != e.data[i]) fd = i;
          errors++;
          $display("FAIL frame_data addr=%0d got_bits=%0d exp_bits=%0d first_diff=%0d",
                   e.addr, $countones(out_data), $countones(e.data), fd);
        end
      end
    end
  end

  task automatic clr_exp();
    expf = '0;
  endtask

  task automatic set_exp(input int i);
    expf = expf | (NB'(1) << i);
  endtask

  // One event per call; a closing event queues the frame held in expf.
  task automatic send(input int x, input int y, input bit p, input longint t,
                      input bit closes, input int addr);
    exp_t e;
    @(posedge clk); #1;
    xc = 14'(x); yc = 14'(y); pol = p; ts = 34'(t); vld = 1'b1;
    if (closes) begin
      e.data = expf; e.addr = 6'(addr); e.cyc = pcyc + 1;
      q.push_back(e);
    end
    @(posedge clk); #1;
    vld = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_valid got=%b exp=0", tag, out_valid); end
    checks++;
    if (out_addr !== 6'd0) begin errors++; $display("FAIL %s_addr got=%0d exp=0", tag, out_addr); end
    checks++;
    if (out_data !== '0) begin errors++; $display("FAIL %s_data got_bits=%0d exp_bits=0", tag, $countones(out_data)); end
  endtask

  // Hold reset for n cycles while events keep arriving.
  task automatic do_reset(input int n, input string tag);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < n; i++) begin
      xc = 14'(i * 7); yc = 14'(i * 5); pol = i[0]; ts = 34'(500000 + i * 150000); vld = 1'b1;
      @(posedge clk); #1;
    end
    vld = 1'b0;
    check_reset_state(tag);
    rst = 1'b1;
  endtask

  initial begin
    do_reset(10, "reset");

    // Basic frame, then the polarity-1 pixel in the next frame.
    send(0, 0, 0, 1000, 0, 0);
    clr_exp(); set_exp(0);
    send(0, 0, 1, 101000, 1, 0);
    clr_exp(); set_exp(1156);
    send(1, 1, 0, 201000, 1, 1);

    // Corner bins plus out-of-range events; an out-of-range event closes.
    send(239, 179, 1, 250000, 0, 0);
    send(120, 90, 0, 260000, 0, 0);
    send(240, 10, 0, 270000, 0, 0);
    clr_exp(); set_exp(0); set_exp(2311); set_exp(595);
    send(5, 180, 0, 301000, 1, 2);
    send(240, 10, 0, 350000, 0, 0);
    clr_exp();
    send(0, 0, 0, 401000, 1, 3);

    // Window edge after a fresh reset.
    do_reset(2, "reset2");
    send(10, 0, 0, 5000, 0, 0);
    send(0, 10, 1, 104999, 0, 0);
    clr_exp(); set_exp(1); set_exp(1190);
    send(0, 0, 0, 105000, 1, 0);

    // Bin edges in x and y, then a backwards timestamp and a long idle gap.
    send(7, 5, 0, 150000, 0, 0);
    send(8, 6, 1, 160000, 0, 0);
    send(232, 0, 0, 170000, 0, 0);
    send(233, 0, 0, 180000, 0, 0);
    clr_exp(); set_exp(0); set_exp(1191); set_exp(32); set_exp(33);
    send(0, 0, 0, 205000, 1, 1);
    send(3, 0, 1, 1000, 0, 0);
    clr_exp(); set_exp(0); set_exp(1156);
    send(0, 0, 0, 900000, 1, 2);

    // Partial frame discarded by a mid-window reset.
    send(20, 20, 0, 900500, 0, 0);
    do_reset(3, "midreset");
    send(0, 0, 1, 2000000, 0, 0);
    clr_exp(); set_exp(1156);
    send(0, 0, 0, 2100000, 1, 0);

    // 64 further closes: addresses 1..63 then wrap to 0.
    clr_exp(); set_exp(0);
    for (int i = 1; i <= 64; i++) send(0, 0, 0, 2100000 + longint'(i) * 100000, 1, i % 64);

    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_frames got=0 exp=%0d", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
